// File: rtl/mem_wb_stage_if.sv
// Execute-to-writeback bus: execute-stage inputs, data-cache response,
// and everything the stage returns (stall, forwarding, regfile write, CSRs).
interface mem_wb_stage_if #(parameter int XLEN = 32);
  logic            x_valid;
  logic [31:0]     x_inst;
  logic [XLEN-1:0] x_pc;
  logic [XLEN-1:0] x_alu_out;
  logic [XLEN-1:0] x_csr_wdata;
  logic [XLEN-1:0] dcache_dout;
  logic            dcache_resp_valid;
  logic            stall;
  logic [31:0]     wb_inst;
  logic [XLEN-1:0] wb_fwd_data;
  logic [31:0]     pp_inst;
  logic [XLEN-1:0] pp_data;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [XLEN-1:0] csr_tohost;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret_cnt;

  modport master (
    output x_valid, x_inst, x_pc, x_alu_out, x_csr_wdata, dcache_dout, dcache_resp_valid,
    input  stall, wb_inst, wb_fwd_data, pp_inst, pp_data, rf_we, rf_wa, rf_wd,
           csr_tohost, cycle_cnt, instret_cnt
  );

  modport slave (
    input  x_valid, x_inst, x_pc, x_alu_out, x_csr_wdata, dcache_dout, dcache_resp_valid,
    output stall, wb_inst, wb_fwd_data, pp_inst, pp_data, rf_we, rf_wa, rf_wd,
           csr_tohost, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Mem/WB stage: registers the retiring instruction, aligns load data, selects
// the writeback value, owns tohost/cycle/instret and stalls on pending loads.
module mem_wb_stage #(
  parameter int          XLEN        = 32,
  parameter logic [11:0] CSR_TOHOST  = 12'h51E,
  parameter logic [11:0] CSR_CYCLE   = 12'hC00,
  parameter logic [11:0] CSR_INSTRET = 12'hC02
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_ARI_I = 7'b0010011;
  localparam logic [6:0] OP_ARI_R = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, csr_wdata_q, csr_wdata_d;
  logic [31:0]     pp_inst_q, pp_inst_d;
  logic [XLEN-1:0] pp_data_q, pp_data_d;
  logic [XLEN-1:0] tohost_q, tohost_d, cycle_q, cycle_d, instret_q, instret_d;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [11:0]     csr_addr;
  logic            is_load, is_jump, is_alu, is_csrrw, writes_rd;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data, csr_old, wb_data;
  logic            stall, rf_we;

  // decode and writeback select
  always_comb begin
    opc       = inst_q[6:0];
    f3        = inst_q[14:12];
    csr_addr  = inst_q[31:20];
    is_load   = (opc == OP_LOAD);
    is_jump   = (opc == OP_JAL) || (opc == OP_JALR);
    is_alu    = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_ARI_I) || (opc == OP_ARI_R);
    is_csrrw  = (opc == OP_SYS) && ((f3 == 3'b001) || (f3 == 3'b101));
    writes_rd = is_load || is_jump || is_alu || is_csrrw;

    off = alu_q[1:0];
    case (off)
      2'd0:    ld_byte = bus.dcache_dout[7:0];
      2'd1:    ld_byte = bus.dcache_dout[15:8];
      2'd2:    ld_byte = bus.dcache_dout[23:16];
      default: ld_byte = bus.dcache_dout[31:24];
    endcase
    ld_half = off[1] ? bus.dcache_dout[31:16] : bus.dcache_dout[15:0];
    case (f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = bus.dcache_dout;
    endcase

    case (csr_addr)
      CSR_TOHOST:  csr_old = tohost_q;
      CSR_CYCLE:   csr_old = cycle_q;
      CSR_INSTRET: csr_old = instret_q;
      default:     csr_old = '0;
    endcase

    wb_data = '0;
    if (is_load)       wb_data = ld_data;
    else if (is_jump)  wb_data = pc_q + XLEN'(4);
    else if (is_alu)   wb_data = alu_q;
    else if (is_csrrw) wb_data = csr_old;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (is_load && !bus.dcache_resp_valid) state_d = LOAD_WAIT;
      LOAD_WAIT: if (bus.dcache_resp_valid)             state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // FSM: outputs (stall depends only on the resident load, whatever the state)
  always_comb begin
    stall = is_load && !bus.dcache_resp_valid;
    rf_we = (inst_q != 32'd0) && writes_rd && (inst_q[11:7] != 5'd0) && !stall;
  end

  // datapath next-state
  always_comb begin
    inst_d      = inst_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    csr_wdata_d = csr_wdata_q;
    pp_inst_d   = pp_inst_q;
    pp_data_d   = pp_data_q;
    tohost_d    = tohost_q;
    instret_d   = instret_q;
    cycle_d     = cycle_q + XLEN'(1);
    if (!stall) begin
      inst_d      = bus.x_valid ? bus.x_inst : 32'd0;
      pc_d        = bus.x_pc;
      alu_d       = bus.x_alu_out;
      csr_wdata_d = bus.x_csr_wdata;
      pp_inst_d   = rf_we ? inst_q : 32'd0;
      pp_data_d   = wb_data;
      if (is_csrrw && (csr_addr == CSR_TOHOST)) tohost_d = csr_wdata_q;
      if (inst_q != 32'd0) instret_d = instret_q + XLEN'(1);
    end
  end

  // FSM + datapath state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      inst_q      <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      csr_wdata_q <= '0;
      pp_inst_q   <= '0;
      pp_data_q   <= '0;
      tohost_q    <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      csr_wdata_q <= csr_wdata_d;
      pp_inst_q   <= pp_inst_d;
      pp_data_q   <= pp_data_d;
      tohost_q    <= tohost_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.wb_inst     = inst_q;
  assign bus.wb_fwd_data = wb_data;
  assign bus.pp_inst     = pp_inst_q;
  assign bus.pp_data     = pp_data_q;
  assign bus.rf_we       = rf_we;
  assign bus.rf_wa       = inst_q[11:7];
  assign bus.rf_wd       = wb_data;
  assign bus.csr_tohost  = tohost_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-encoded instructions, hand-computed results.
module tb_mem_wb_stage;
  localparam logic [31:0] ADDI  = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] LB    = 32'h00008303; // lb  x6
  localparam logic [31:0] LH    = 32'h00009303; // lh  x6
  localparam logic [31:0] LBU   = 32'h0000C303; // lbu x6
  localparam logic [31:0] LHU   = 32'h0000D303; // lhu x6
  localparam logic [31:0] LW    = 32'h0000A403; // lw  x8
  localparam logic [31:0] CSRW  = 32'h51E09073; // csrrw x0,tohost,x1
  localparam logic [31:0] CSRRW = 32'h51E093F3; // csrrw x7,tohost,x1
  localparam logic [31:0] CSRUK = 32'h340094F3; // csrrw x9,0x340,x1
  localparam logic [31:0] CSRCY = 32'hC0009073; // csrrw x0,cycle,x1
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] JAL   = 32'h000000EF; // jal x1,0

  logic clk = 1'b0;
  logic reset;
  int   total = 0, bad = 0, ncyc = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if bus();
  mem_wb_stage dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic step();
    @(posedge clk);
    if (reset) ncyc++; else ncyc = 0;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] w);
    bus.x_valid = v; bus.x_inst = i; bus.x_pc = pc; bus.x_alu_out = a; bus.x_csr_wdata = w;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.dcache_dout = 32'h0; bus.dcache_resp_valid = 1'b1;
    drive(1'b1, ADDI, 32'h100, 32'd7, 32'd0);
    step(); step();
    total++; if (bus.wb_inst !== 32'd0) begin bad++; $display("FAIL rst_wb_inst got=%h exp=0", bus.wb_inst); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%b exp=0", bus.rf_we); end
    total++; if (bus.pp_inst !== 32'd0 || bus.pp_data !== 32'd0) begin bad++; $display("FAIL rst_pp got=%h/%h exp=0/0", bus.pp_inst, bus.pp_data); end
    total++; if (bus.csr_tohost !== 32'd0 || bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_csrs got=%h/%h/%h exp=0/0/0", bus.csr_tohost, bus.cycle_cnt, bus.instret_cnt); end
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    total++; if (bus.cycle_cnt !== 32'd1) begin bad++; $display("FAIL rst_cycle1 got=%h exp=1", bus.cycle_cnt); end
  endtask

  task automatic test_addi();
    drive(1'b1, ADDI, 32'h100, 32'd7, 32'd0);
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'd7) begin
      bad++; $display("FAIL addi_wb got=%b/%0d/%h exp=1/5/7", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    total++; if (bus.pp_inst !== ADDI || bus.pp_data !== 32'd7) begin
      bad++; $display("FAIL addi_pp got=%h/%h exp=%h/7", bus.pp_inst, bus.pp_data, ADDI); end
    total++; if (bus.wb_inst !== 32'd0 || bus.instret_cnt !== 32'd1) begin
      bad++; $display("FAIL bubble_in got=%h/%0d exp=0/1", bus.wb_inst, bus.instret_cnt); end
    step();
    total++; if (bus.instret_cnt !== 32'd1 || bus.pp_inst !== 32'd0) begin
      bad++; $display("FAIL bubble_retire got=%0d/%h exp=1/0", bus.instret_cnt, bus.pp_inst); end
  endtask

  task automatic test_load_align();
    bus.dcache_dout = 32'h80FF_0000; bus.dcache_resp_valid = 1'b1;
    drive(1'b1, LB, 32'h104, 32'h1003, 32'd0); step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd6 || bus.rf_wd !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL lb_sext got=%b/%0d/%h exp=1/6/ffffff80", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    drive(1'b1, LHU, 32'h108, 32'h1002, 32'd0); step();
    total++; if (bus.rf_wd !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_zext got=%h exp=000080ff", bus.rf_wd); end
    drive(1'b1, LBU, 32'h10C, 32'h1002, 32'd0); step();
    total++; if (bus.rf_wd !== 32'h0000_00FF) begin bad++; $display("FAIL lbu_zext got=%h exp=000000ff", bus.rf_wd); end
    drive(1'b1, LH, 32'h110, 32'h1003, 32'd0); step();
    total++; if (bus.rf_wd !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh_sext_off0 got=%h exp=ffff80ff", bus.rf_wd); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
  endtask

  task automatic test_load_stall();
    bus.dcache_resp_valid = 1'b0;
    drive(1'b1, LW, 32'h120, 32'h2001, 32'd0); step();
    drive(1'b1, ADDI, 32'h124, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0 || bus.wb_inst !== LW) begin
        bad++; $display("FAIL lw_wait%0d got=%b/%b/%h exp=1/0/%h", i, bus.stall, bus.rf_we, bus.wb_inst, LW); end
      total++; if (bus.instret_cnt !== 32'd5) begin bad++; $display("FAIL lw_wait_instret%0d got=%0d exp=5", i, bus.instret_cnt); end
      step();
    end
    bus.dcache_dout = 32'hDEAD_BEEF; bus.dcache_resp_valid = 1'b1; #1;
    total++; if (bus.stall !== 1'b0 || bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd8 || bus.rf_wd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL lw_resp got=%b/%b/%0d/%h exp=0/1/8/deadbeef", bus.stall, bus.rf_we, bus.rf_wa, bus.rf_wd); end
    step();
    total++; if (bus.instret_cnt !== 32'd6 || bus.wb_inst !== ADDI) begin
      bad++; $display("FAIL lw_retire got=%0d/%h exp=6/%h", bus.instret_cnt, bus.wb_inst, ADDI); end
    total++; if (bus.pp_inst !== LW || bus.pp_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL lw_pp got=%h/%h exp=%h/deadbeef", bus.pp_inst, bus.pp_data, LW); end
    total++; if (bus.cycle_cnt !== ncyc) begin bad++; $display("FAIL cycle_in_stall got=%0d exp=%0d", bus.cycle_cnt, ncyc); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
  endtask

  task automatic test_csr();
    drive(1'b1, CSRW, 32'h130, 32'd0, 32'd1); step();
    total++; if (bus.rf_we !== 1'b0 || bus.csr_tohost !== 32'd0) begin
      bad++; $display("FAIL csrw_pre got=%b/%h exp=0/0", bus.rf_we, bus.csr_tohost); end
    drive(1'b1, CSRRW, 32'h134, 32'd0, 32'd2); step();
    total++; if (bus.csr_tohost !== 32'd1) begin bad++; $display("FAIL csrw_tohost got=%h exp=1", bus.csr_tohost); end
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd7 || bus.rf_wd !== 32'd1) begin
      bad++; $display("FAIL csrrw_old got=%b/%0d/%h exp=1/7/1", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    drive(1'b1, CSRUK, 32'h138, 32'd0, 32'd5); step();
    total++; if (bus.csr_tohost !== 32'd2) begin bad++; $display("FAIL csrrw_tohost got=%h exp=2", bus.csr_tohost); end
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wd !== 32'd0) begin
      bad++; $display("FAIL csr_unknown got=%b/%h exp=1/0", bus.rf_we, bus.rf_wd); end
    drive(1'b1, CSRCY, 32'h13C, 32'd0, 32'h0); step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
    total++; if (bus.cycle_cnt !== ncyc || bus.csr_tohost !== 32'd2) begin
      bad++; $display("FAIL csr_cycle_ro got=%0d/%h exp=%0d/2", bus.cycle_cnt, bus.csr_tohost, ncyc); end
  endtask

  task automatic test_branch_store_jal();
    drive(1'b1, BEQ, 32'h140, 32'd0, 32'd0); step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL beq_we got=%b exp=0", bus.rf_we); end
    drive(1'b1, SW, 32'h144, 32'h3000, 32'd0); step();
    total++; if (bus.rf_we !== 1'b0 || bus.pp_inst !== 32'd0) begin
      bad++; $display("FAIL sw_we_pp got=%b/%h exp=0/0", bus.rf_we, bus.pp_inst); end
    drive(1'b1, JAL, 32'h200, 32'h0, 32'd0); step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd1 || bus.rf_wd !== 32'h204 || bus.pp_inst !== 32'd0) begin
      bad++; $display("FAIL jal_link got=%b/%0d/%h/%h exp=1/1/204/0", bus.rf_we, bus.rf_wa, bus.rf_wd, bus.pp_inst); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
    total++; if (bus.pp_inst !== JAL || bus.pp_data !== 32'h204) begin
      bad++; $display("FAIL jal_pp got=%h/%h exp=%h/204", bus.pp_inst, bus.pp_data, JAL); end
  endtask

  task automatic test_reset_mid_wait();
    bus.dcache_resp_valid = 1'b0;
    drive(1'b1, LW, 32'h150, 32'h2000, 32'd0); step();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL midwait_stall got=%b exp=1", bus.stall); end
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
    total++; if (bus.stall !== 1'b0 || bus.wb_inst !== 32'd0 || bus.rf_we !== 1'b0 || bus.cycle_cnt !== 32'd0) begin
      bad++; $display("FAIL midwait_rst got=%b/%h/%b/%0d exp=0/0/0/0", bus.stall, bus.wb_inst, bus.rf_we, bus.cycle_cnt); end
    reset = 1'b1; step();
    total++; if (bus.cycle_cnt !== 32'd1 || bus.instret_cnt !== 32'd0 || bus.rf_we !== 1'b0) begin
      bad++; $display("FAIL midwait_release got=%0d/%0d/%b exp=1/0/0", bus.cycle_cnt, bus.instret_cnt, bus.rf_we); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_align();
    test_load_stall();
    test_csr();
    test_branch_store_jal();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final stage of the 3-stage pipeline; sits directly downstream of the execute stage.
- Registers the retiring instruction and aligns/extends load data from the data cache.
- Selects the register-file writeback value, maintains CSRs (tohost, cycle, instret) and stalls the pipeline on outstanding loads.
- Returns the Mem/WB instruction and the previous-previous instruction, each with its result, to the execute stage for forwarding.

Parameters:
- XLEN, 32, datapath width.
- CSR_TOHOST, 12'h51E, address of tohost CSR.
- CSR_CYCLE, 12'hC00, address of cycle counter CSR.
- CSR_INSTRET, 12'hC02, address of retired-instruction counter CSR.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
- x_valid  in  1  execute-stage instruction is valid (0 = flushed bubble)
- x_inst  in  32  execute-stage instruction
- x_pc  in  32  execute-stage PC
- x_alu_out  in  32  ALU result / effective load address
- x_csr_wdata  in  32  CSR write operand (rs1 value or zero-extended zimm, selected upstream)
- dcache_dout  in  32  load data word from data cache
- dcache_resp_valid  in  1  dcache_dout valid for the load in this stage
- stall  out  1  freeze upstream stages and this stage's input registers
- wb_inst  out  32  instruction in Mem/WB (0 when bubble)
- wb_fwd_data  out  32  writeback value of wb_inst
- pp_inst  out  32  previous-previous retired instruction (0 if it wrote no rd)
- pp_data  out  32  writeback value of pp_inst
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
- csr_tohost  out  32  tohost CSR value
- cycle_cnt  out  32  cycle counter
- instret_cnt  out  32  retired-instruction counter

Behaviour:
- Reset: all registers 0 (wb_inst, pc, alu, csr_wdata, pp_inst, pp_data, csr_tohost, cycle_cnt, instret_cnt); FSM=RUN.
- Reset outputs: stall=0, rf_we=0.
- Reset mid-load-wait: returns to RUN and drops the pending load without writeback.
- Advance: on each edge with stall==0, latch x_inst/x_pc/x_alu_out/x_csr_wdata; if x_valid==0, latch inst=0.
- While stall==1, input registers hold and x_* inputs are ignored.
- Writeback value, combinational from Mem/WB registers:
  - LOAD: aligned dcache_dout.
  - JAL/JALR: pc+4.
  - LUI/AUIPC/ARI_R/ARI_I: alu_out.
  - CSRRW/CSRRWI: old CSR value (tohost, cycle_cnt or instret_cnt by address; any other address reads 0).
  - BRANCH/STORE/other: no write.
- Load alignment, off = alu_out[1:0]:
  - LB/LBU: byte off, sign-/zero-extended.
  - LH/LHU: half off[1], sign-/zero-extended; off[0] ignored.
  - LW: full word, off ignored.
- rf_we = (inst!=0) & writes-rd opcode & rd!=0 & !stall; rf_wa=inst[11:7]; rf_wd=wb_fwd_data.
- FSM states RUN and LOAD_WAIT:
  - RUN -> LOAD_WAIT when wb_inst is LOAD and dcache_resp_valid==0.
  - LOAD_WAIT -> RUN on the first cycle dcache_resp_valid==1; writeback occurs that cycle.
  - stall = (wb_inst is LOAD) & !dcache_resp_valid, in either state.
- pp update, on advance only: pp_inst <= (rf_we ? wb_inst : 0); pp_data <= wb_fwd_data.
- CSR write on advance when the retiring instruction is CSRRW/CSRRWI to CSR_TOHOST: csr_tohost <= csr_wdata.
  - Writes to cycle/instret addresses are ignored.
  - The old value is returned to rd the same cycle as the write.
- cycle_cnt increments every cycle out of reset, including stalls; wraps 0xFFFFFFFF->0.
- instret_cnt increments on advance when wb_inst!=0; wraps.

Test Plan:
- Reset held low 2 cycles with x_valid=1 -> all outputs 0, stall=0; cycle_cnt=1 one cycle after release.
- addi x5,x0,7 (alu_out=7) then bubble -> next cycle rf_we=1, rf_wa=5, rf_wd=7; following advance pp_inst=addi, pp_data=7.
- lb x6 with alu_out[1:0]=2'b11, dcache_dout=0x80FF_0000 -> rf_wd=0xFFFF_FF80; lhu off=2'b10 same data -> 0x0000_80FF.
- lw, dcache_resp_valid low 3 cycles then high -> stall=1 for exactly 3 cycles, rf_we only on the 4th, inputs frozen; instret_cnt +1 once.
- csrw tohost with csr_wdata=1 (rd=x0) -> next edge csr_tohost=1, rf_we=0; csrrw x7,tohost,2 -> rf_wd=1, then csr_tohost=2.
- beq/sw in stage -> rf_we=0, pp_inst=0 after advance; x_valid=0 bubble -> wb_inst=0, instret_cnt unchanged.
